mem_port_arbiter: RTL

- Shares the single data-memory request port (addr/data/rw/id/valid in; data/id/ready/stall out) between two requesters: requester 0 is the load/store queue, requester 1 is a second client such as an instruction-fill or debug path.
- Arbitrates round-robin and remaps each requester's 4-bit id onto a private memory tag.
- Tracks outstanding requests in a tag table, and routes each out-of-order memory response back to its owner with the owner's original id.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin memory port arbiter with tag remapping
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    input  logic [ID_W-1:0]   r0_id,
    output logic              r0_grant,
    input  logic              r1_valid,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    input  logic [ID_W-1:0]   r1_id,
    output logic              r1_grant,
    output logic              m_valid,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic [ID_W-1:0]   m_id,
    input  logic              m_stall,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [ID_W-1:0]   m_rid,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [ID_W-1:0]   rsp0_id,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ID_W-1:0]   rsp1_id,
    output logic [ID_W:0]     outstanding,
    output logic              spurious
);
    localparam int DEPTH = 1 << ID_W;
    localparam logic [ID_W:0] CNT_ONE = {{ID_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_owner;
    logic [ID_W-1:0]  tag_id [DEPTH];
    logic             last_grant;

    logic             has_free;
    logic [ID_W-1:0]  free_tag;
    logic             can_issue;
    logic             grant_any;
    logic             rsp_hit;

    // Lowest free tag; a tag being freed this cycle is still marked valid, so it is never picked.
    always_comb begin
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!tag_valid[i]) free_tag = ID_W'(i);
        end
    end

    assign has_free  = |(~tag_valid);
    assign can_issue = !m_stall && has_free;
    assign r0_grant  = can_issue && r0_valid && (!r1_valid || last_grant);
    assign r1_grant  = can_issue && r1_valid && (!r0_valid || !last_grant);
    assign grant_any = r0_grant || r1_grant;
    assign rsp_hit   = m_ready && tag_valid[m_rid];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid   <= '0;
            last_grant  <= 1'b1;
            m_valid     <= 1'b0;
            m_rw        <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
            m_id        <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp0_id     <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_data   <= '0;
            rsp1_id     <= '0;
            outstanding <= '0;
            spurious    <= 1'b0;
        end else begin
            m_valid    <= grant_any;
            rsp0_valid <= rsp_hit && !tag_owner[m_rid];
            rsp1_valid <= rsp_hit && tag_owner[m_rid];
            spurious   <= m_ready && !tag_valid[m_rid];

            if (grant_any) begin
                m_rw                <= r1_grant ? r1_rw   : r0_rw;
                m_addr              <= r1_grant ? r1_addr : r0_addr;
                m_data              <= r1_grant ? r1_data : r0_data;
                m_id                <= free_tag;
                tag_valid[free_tag] <= 1'b1;
                tag_owner[free_tag] <= r1_grant;
                tag_id[free_tag]    <= r1_grant ? r1_id : r0_id;
                last_grant          <= r1_grant;
            end

            if (rsp_hit) begin
                tag_valid[m_rid] <= 1'b0;
                if (tag_owner[m_rid]) begin
                    rsp1_data <= m_rdata;
                    rsp1_id   <= tag_id[m_rid];
                end else begin
                    rsp0_data <= m_rdata;
                    rsp0_id   <= tag_id[m_rid];
                end
            end

            case ({grant_any, rsp_hit})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
